// File: rtl/e_pkg.sv
// Shared Execute-stage multiply types: op encodings, sequencer states and
// the operand-signedness rules for each op.
package e_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_H   = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HU  = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_BPC   = 4;
  localparam int MUL_ITER  = MUL_WIDTH / MUL_BPC;

  // rs1 is signed for MULH and MULHSU; rs2 only for MULH.
  function automatic logic op_a_signed(mul_op_t op);
    return (op == MUL_H) || (op == MUL_HSU);
  endfunction

  function automatic logic op_b_signed(mul_op_t op);
    return (op == MUL_H);
  endfunction

endpackage

// File: rtl/e_mul_seq_if.sv
// Request/response bundle between the E-stage pause controller (master)
// and the iterative multiplier (slave).
interface e_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_flush;
  logic             o_pause;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;

  modport master (
    output i_start, i_op, i_a, i_b, i_flush,
    input  o_pause, o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_flush,
    output o_pause, o_busy, o_done, o_result
  );
endinterface

// File: rtl/e_mul_prep.sv
// Operand sign handling: turns raw rs1/rs2 into unsigned magnitudes and the
// sign of the final product, according to the multiply op.
module e_mul_prep
  import e_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   mag_a,
  output logic [WIDTH:0]   mag_b,
  output logic             neg
);

  logic signed [WIDTH:0] ext_a;
  logic signed [WIDTH:0] ext_b;

  // One extra bit keeps |most-negative| = 2^(WIDTH-1) representable.
  always_comb begin
    ext_a = {op_a_signed(mul_op_t'(op)) & a[WIDTH-1], a};
    ext_b = {op_b_signed(mul_op_t'(op)) & b[WIDTH-1], b};
    mag_a = ext_a[WIDTH] ? -ext_a : ext_a;
    mag_b = ext_b[WIDTH] ? -ext_b : ext_b;
    neg   = ext_a[WIDTH] ^ ext_b[WIDTH];
  end

endmodule

// File: rtl/e_mul_seq.sv
// Iterative radix-2^BPC shift-add multiplier for the Execute stage. Takes one
// op, stalls the pipeline while it iterates, then pulses done with the result.
module e_mul_seq
  import e_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  e_mul_seq_if.slave  bus
);

  localparam int ITER   = WIDTH / BPC;
  localparam int CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int PROD_W = 2 * WIDTH;
  localparam int PART_W = WIDTH + 1 + BPC;

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             neg_q;
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   mplier;
  logic [PROD_W-1:0] acc;
  logic [WIDTH-1:0] result;

  logic [WIDTH:0]    mag_a;
  logic [WIDTH:0]    mag_b;
  logic              neg;
  logic [BPC-1:0]    digit;
  logic [PART_W-1:0] partial;
  logic [PROD_W-1:0] acc_step;
  logic              start_ok;
  logic              last;
  int                shamt;

  e_mul_prep #(.WIDTH(WIDTH)) u_prep (
    .op    (bus.i_op),
    .a     (bus.i_a),
    .b     (bus.i_b),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .neg   (neg)
  );

  // Apply the product sign and pick the architectural word.
  function automatic logic [WIDTH-1:0] select_word(logic [PROD_W-1:0] mag,
                                                   logic sgn, logic [1:0] op);
    logic [PROD_W-1:0] p;
    p = sgn ? (~mag + PROD_W'(1)) : mag;
    return (mul_op_t'(op) == MUL_LO) ? p[WIDTH-1:0] : p[PROD_W-1:WIDTH];
  endfunction

  always_comb begin
    start_ok = bus.i_start && !bus.i_flush;
    last     = (cnt == CNT_W'(ITER - 1));
    digit    = mplier[BPC-1:0];
    partial  = PART_W'(mcand) * PART_W'(digit);
    shamt    = int'(cnt) * BPC;
    acc_step = acc + (PROD_W'(partial) << shamt);
  end

  // Sequencer: IDLE/DONE accept a new op, BUSY consumes one digit per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            op_q   <= bus.i_op;
            mcand  <= mag_a;
            mplier <= mag_b;
            neg_q  <= neg;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end else begin
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        BUSY: begin
          if (bus.i_flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            acc    <= acc_step;
            mplier <= mplier >> BPC;
            if (last) begin
              result <= select_word(acc_step, neg_q, op_q);
              cnt    <= '0;
              state  <= DONE;
            end else begin
              cnt    <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Pause is combinational so the issuing instruction stalls in its own cycle.
  assign bus.o_pause  = !i_rst && ((state == BUSY) ||
                                   ((state != BUSY) && bus.i_start));
  assign bus.o_busy   = (state == BUSY);
  assign bus.o_done   = (state == DONE);
  assign bus.o_result = result;

endmodule

// File: tb/tb_e_mul_seq.sv
// Directed bench for e_mul_seq: expected products come from a 66-bit signed
// reference model and are queued at issue, popped when done pulses.
module tb_e_mul_seq;
  import e_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  e_mul_seq_if #(.WIDTH(32)) mif ();

  e_mul_seq #(.WIDTH(32), .BPC(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (mif.slave)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;
  logic [31:0] sb[$];

  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [65:0] sa, sb_, p;
    sa  = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'd0, a};
    sb_ = (op == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
    p   = sa * sb_;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (mif.o_done) begin
      chk("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk("sb_result", mif.o_result, sb.pop_front());
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit push);
    mif.i_start = 1'b1;
    mif.i_op    = op;
    mif.i_a     = a;
    mif.i_b     = b;
    if (push) sb.push_back(model(op, a, b));
  endtask

  // Latency counted in cycles from the issue edge; 0 means it never finished.
  task automatic wait_done(output int lat, output logic first_busy);
    lat = 0;
    first_busy = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 1) begin
        mif.i_start = 1'b0;
        first_busy = mif.o_busy;
      end
      if (mif.o_done) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    int lat;
    logic fb;
    issue(op, a, b, 1'b1);
    wait_done(lat, fb);
    chk({tag, "_lat"}, lat, 32'd8);
    chk(tag, mif.o_result, exp);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int pc, bc, dc, done_at, lat, dn;
    logic fb;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    mif.i_start = 1'b0;
    mif.i_op    = 2'b00;
    mif.i_a     = '0;
    mif.i_b     = '0;
    mif.i_flush = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    mif.i_start = 1'b1;
    #1 chk("pause_in_reset", 32'(mif.o_pause), 32'd0);
    mif.i_start = 1'b0;
    rst = 1'b0;
    cyc();
    chk("rst_busy", 32'(mif.o_busy), 32'd0);
    chk("rst_done", 32'(mif.o_done), 32'd0);
    chk("rst_result", mif.o_result, 32'd0);
    chk("rst_pause", 32'(mif.o_pause), 32'd0);

    // MUL 3x5 with cycle-accurate pause/busy/done profile
    issue(MUL_LO, 32'd3, 32'd5, 1'b1);
    #1 pc = mif.o_pause ? 1 : 0;
    bc = 0; dc = 0; done_at = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 1) mif.i_start = 1'b0;
      pc += mif.o_pause ? 1 : 0;
      bc += mif.o_busy ? 1 : 0;
      dc += mif.o_done ? 1 : 0;
      if (mif.o_done && done_at == 0) begin
        done_at = k;
        chk("mul_3x5", mif.o_result, 32'h0000000F);
      end
    end
    chk("pause_cycles", pc, 32'd9);
    chk("busy_cycles", bc, 32'd8);
    chk("done_cycles", dc, 32'd1);
    chk("done_latency", done_at - 1, 32'd8);

    run(MUL_HU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    run(MUL_H,   32'h80000000, 32'h80000000, 32'h40000000, "mulh_minmin");
    run(MUL_HSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "mulhsu_neg1");
    run(MUL_LO,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, "mul_min_neg1");
    run(MUL_H,   32'h80000000, 32'h00000001, 32'hFFFFFFFF, "mulh_min_one");
    run(MUL_HU,  32'h00000000, 32'h00001234, 32'h00000000, "zero_operand");
    for (int r = 0; r < 6; r++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      run(rop, ra, rb, model(rop, ra, rb), "random");
    end

    // Back-to-back: new op issued in the DONE cycle; start while BUSY ignored
    issue(MUL_LO, 32'd2, 32'd9, 1'b1);
    done_at = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (k == 1 || k == 5) mif.i_start = 1'b0;
      if (k == 4) issue(MUL_LO, 32'd100, 32'd100, 1'b0);
      if (mif.o_done) begin
        done_at = k;
        break;
      end
    end
    chk("b2b_first_lat", done_at - 1, 32'd8);
    chk("b2b_first", mif.o_result, 32'd18);
    issue(MUL_LO, 32'd7, 32'd6, 1'b1);
    wait_done(lat, fb);
    chk("b2b_no_idle", 32'(fb), 32'd1);
    chk("b2b_second_lat", lat, 32'd8);
    chk("b2b_second", mif.o_result, 32'h0000002A);
    for (int k = 0; k < 4; k++) cyc();
    chk("sb_empty", sb.size(), 32'd0);

    // Flush in BUSY cycle 4
    issue(MUL_LO, 32'd5, 32'd5, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 1) mif.i_start = 1'b0;
    end
    mif.i_flush = 1'b1;
    cyc();
    mif.i_flush = 1'b0;
    chk("flush_busy", 32'(mif.o_busy), 32'd0);
    chk("flush_done", 32'(mif.o_done), 32'd0);
    chk("flush_pause", 32'(mif.o_pause), 32'd0);
    chk("flush_result_kept", mif.o_result, 32'h0000002A);
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      dn += mif.o_done ? 1 : 0;
    end
    chk("flush_no_done", dn, 32'd0);

    // Reset in BUSY cycle 3
    issue(MUL_LO, 32'd6, 32'd6, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 1) mif.i_start = 1'b0;
    end
    rst = 1'b1;
    cyc();
    chk("midrst_busy", 32'(mif.o_busy), 32'd0);
    chk("midrst_done", 32'(mif.o_done), 32'd0);
    chk("midrst_result", mif.o_result, 32'd0);
    chk("midrst_pause", 32'(mif.o_pause), 32'd0);
    rst = 1'b0;
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      dn += mif.o_done ? 1 : 0;
    end
    chk("midrst_no_done", dn, 32'd0);
    run(MUL_LO, 32'd3, 32'd3, 32'd9, "post_reset");
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
